neuron_feeder: RTL and testbench
================================

Name: neuron_feeder

Overview:
- Producer/controller for the neuron datapath. It sits upstream of a neuron_Nbits instance.
- Buffers up to DEPTH (weight, input) pairs loaded over a valid/ready stream.
- On start it clears the neuron accumulator, streams K pairs on W/X/en, then captures the ReLU output and returns it on a valid/ready result port.
- It is the driving end of the neuron's W/X/en/rst interface and the consuming end of its Out.

Parameters:
- N, 18, data width of W, X and result (matches neuron N)
- DEPTH, 16, pair buffer depth (power of two)
- ADDR_W, 4, log2(DEPTH)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  pair offered
- load_ready  out  1  pair accepted when load_valid & load_ready
- load_w  in  N  weight (two's complement)
- load_x  in  N  input (two's complement)
- buf_clr  in  1  empty the buffer (IDLE only)
- len  in  ADDR_W+1  term count K, sampled with start
- start  in  1  begin a neuron evaluation
- err  out  1  one-cycle pulse: start rejected
- busy  out  1  state != IDLE
- n_w  out  N  to neuron W
- n_x  out  N  to neuron X
- n_en  out  1  to neuron en
- n_rst_n  out  1  to neuron rst (active-low accumulator clear)
- n_out  in  N  from neuron Out
- res_data  out  N  captured neuron result
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, cnt=0, rd_ptr=0, res_data=0.
  - res_valid=0, err=0, busy=0, n_en=0, n_w=0, n_x=0.
  - n_rst_n=0 while rst is high, so the neuron is cleared too.
  - load_ready=0 while rst is high.
  - Reset mid-operation aborts immediately; no result is produced.
- Buffer: two DEPTH×N arrays (W, X) plus cnt (0..DEPTH).
  - load_ready = (state==IDLE) & (cnt<DEPTH) & !start & !buf_clr.
  - On accept: buf[cnt] <= pair; cnt <= cnt+1.
  - Contents and cnt persist across evaluations, so weights can be reused.
  - buf_clr in IDLE sets cnt=0 and wins over a load in the same cycle. buf_clr outside IDLE is ignored.
- State machine:
  - IDLE:
    - start with 1<=len<=cnt: latch K=len, go to CLEAR.
    - start with len==0 or len>cnt: err=1 for one cycle, stay in IDLE.
  - CLEAR (1 cycle): n_rst_n=0, rd_ptr<=0, then go to STREAM.
  - STREAM (K cycles):
    - n_en=1, n_w=bufW[rd_ptr], n_x=bufX[rd_ptr] (combinational from a registered rd_ptr); rd_ptr increments each cycle.
    - After the cycle with rd_ptr==K-1, go to SETTLE.
  - SETTLE (1 cycle): n_en=0. At the end of the cycle, res_data <= n_out and res_valid <= 1; go to RESULT.
  - RESULT:
    - res_valid=1 and res_data held stable until res_ready=1; then res_valid <= 0 and go to IDLE.
    - start is ignored (no err) while busy.
- Outside CLEAR/STREAM: n_en=0, n_w=0, n_x=0, n_rst_n=1.
- Latency: start accepted at edge t → CLEAR in cycle t+1 → STREAM in cycles t+2..t+1+K → SETTLE in t+2+K → res_valid=1 from t+3+K.
- If res_ready is already high, RESULT lasts one cycle and the next start is accepted in IDLE the cycle after.
- K=DEPTH: rd_ptr reaches DEPTH-1, and the increment wrap to 0 is harmless.
- Arithmetic is done in the neuron. The result is the upper N bits of the 2N-bit signed accumulation, or 0 if the accumulation is negative.

Test Plan:
- Load 3 pairs (W=512, X=512); start, len=3 → n_en high for exactly 3 cycles; res_data=3; res_valid first seen 6 cycles after the start edge.
- Load (W=-512, X=512) and (W=512, X=512); start, len=1 → res_data=0 (ReLU). Then start, len=2 → res_data=0 (sum=0), which also shows the accumulator was cleared between runs.
- cnt=2, start with len=3, then len=0 → err pulses once each; busy stays 0; n_en never rises.
- Fill 16 pairs while holding load_valid=1 → load_ready drops after the 16th accept; a 17th pair is not written; start len=16 → 16 en cycles, correct sum.
- Hold res_ready=0 for 5 cycles in RESULT → res_valid and res_data stable, load_ready=0, start ignored. Then res_ready=1 → IDLE next cycle.
- Assert rst in the middle of STREAM → next cycle state is IDLE, n_en=0, n_rst_n=0 during rst, cnt=0, res_valid never asserted.

Source files
------------

// File: rtl/neuron_feeder.sv
// Pair buffer and sequencer that drives a neuron_Nbits instance: clears the
// accumulator, streams K buffered (W, X) pairs, then returns the ReLU output.
module neuron_feeder #(
  parameter int N      = 18,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [N-1:0]      load_w,
  input  logic [N-1:0]      load_x,
  input  logic              buf_clr,
  input  logic [ADDR_W:0]   len,
  input  logic              start,
  output logic              err,
  output logic              busy,
  output logic [N-1:0]      n_w,
  output logic [N-1:0]      n_x,
  output logic              n_en,
  output logic              n_rst_n,
  input  logic [N-1:0]      n_out,
  output logic [N-1:0]      res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, SETTLE, RESULT} state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t              state, state_nxt;
  logic [N-1:0]        wbuf [DEPTH];
  logic [N-1:0]        xbuf [DEPTH];
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W:0]     k;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                start_ok;
  logic                load_fire;
  logic                last;

  assign start_ok  = (len != '0) && (len <= cnt);
  assign load_fire = load_valid && load_ready;
  assign last      = ({1'b0, rd_ptr} == (k - 1'b1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && start_ok) state_nxt = CLEAR;
      CLEAR:   state_nxt = STREAM;
      STREAM:  if (last) state_nxt = SETTLE;
      SETTLE:  state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    load_ready = (state == IDLE) && (cnt < FULL) && !start && !buf_clr && !rst;
    n_en       = (state == STREAM);
    n_w        = n_en ? wbuf[rd_ptr] : '0;
    n_x        = n_en ? xbuf[rd_ptr] : '0;
    // Neuron accumulator is held clear for the whole of our own reset too.
    n_rst_n    = !(rst || (state == CLEAR));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      k         <= '0;
      rd_ptr    <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (state == IDLE) && start && !start_ok;

      if ((state == IDLE) && buf_clr) cnt <= '0;
      else if (load_fire)             cnt <= cnt + 1'b1;

      if ((state == IDLE) && start && start_ok) k <= len;

      unique case (state)
        CLEAR:   rd_ptr <= '0;
        STREAM:  rd_ptr <= rd_ptr + 1'b1;
        SETTLE: begin
          res_data  <= n_out;
          res_valid <= 1'b1;
        end
        RESULT:  if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Pair storage carries no reset; cnt alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      wbuf[cnt[ADDR_W-1:0]] <= load_w;
      xbuf[cnt[ADDR_W-1:0]] <= load_x;
    end
  end

endmodule

// File: tb/tb_neuron_feeder.sv
// Scoreboard bench for neuron_feeder with a behavioural neuron accumulator.
module tb_neuron_feeder;

  localparam int N     = 18;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid, load_ready;
  logic [N-1:0]  load_w, load_x;
  logic          buf_clr;
  logic [AW:0]   len;
  logic          start, err, busy;
  logic [N-1:0]  n_w, n_x, n_out, res_data;
  logic          n_en, n_rst_n, res_valid, res_ready;

  always #5 clk = ~clk;

  neuron_feeder #(.N(N), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_w(load_w), .load_x(load_x),
    .buf_clr(buf_clr), .len(len), .start(start),
    .err(err), .busy(busy),
    .n_w(n_w), .n_x(n_x), .n_en(n_en), .n_rst_n(n_rst_n), .n_out(n_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  // Neuron: signed MAC into a 2N-bit accumulator, ReLU of the upper N bits.
  logic signed [2*N-1:0] acc;
  int en_cycles = 0;
  always @(posedge clk) begin
    if (!n_rst_n)  acc <= '0;
    else if (n_en) acc <= acc + $signed(n_w) * $signed(n_x);
    if (n_en) en_cycles++;
  end
  assign n_out = acc[2*N-1] ? '0 : acc[2*N-1:N];

  logic signed [N-1:0] mw [DEPTH];
  logic signed [N-1:0] mx [DEPTH];
  int                  mcnt = 0;
  logic [N-1:0]        exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] expect_res(input int k);
    longint s = 0;
    for (int i = 0; i < k; i++) s += longint'(mw[i]) * longint'(mx[i]);
    return (s < 0) ? '0 : N'(s >>> N);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one pair from IDLE; load_valid is left high for back-to-back use.
  task automatic load_pair(input int w, input int x);
    bit exp_rdy;
    exp_rdy    = (mcnt < DEPTH);
    load_valid = 1'b1;
    load_w     = N'(w);
    load_x     = N'(x);
    @(negedge clk);
    check_eq("load_ready", load_ready, exp_rdy);
    tick();
    if (exp_rdy) begin
      mw[mcnt] = N'(w);
      mx[mcnt] = N'(x);
      mcnt++;
    end
  endtask

  task automatic clear_buf();
    buf_clr    = 1'b1;
    load_valid = 1'b1;
    @(negedge clk);
    check_eq("ready_during_clr", load_ready, 0);
    tick();
    buf_clr    = 1'b0;
    load_valid = 1'b0;
    mcnt       = 0;
  endtask

  task automatic run_eval(input int k);
    bit ok;
    int lat, en0;
    ok    = (k != 0) && (k <= mcnt);
    start = 1'b1;
    len   = k[AW:0];
    @(negedge clk);
    check_eq("ready_at_start", load_ready, 0);
    if (ok) exp_q.push_back(expect_res(k));
    en0 = en_cycles;
    tick();
    start = 1'b0;
    check_eq("err", err, !ok);
    check_eq("busy", busy, ok);
    if (ok) begin
      // lat counts edges from the start edge inclusive; result arrives at t+3+K
      lat = 1;
      while (!res_valid && lat < 200) begin
        tick();
        lat++;
      end
      check_eq("latency", lat, k + 3);
      check_eq("en_cycles", en_cycles - en0, k);
      if (res_ready) begin
        tick();
        check_eq("idle_after_res", busy, 0);
        check_eq("valid_cleared", res_valid, 0);
      end
    end else begin
      tick();
      check_eq("err_one_cycle", err, 0);
      check_eq("no_en_on_err", en_cycles - en0, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      check_eq("result_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("res_data", res_data, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    logic [N-1:0] held;
    rst = 1'b1; load_valid = 1'b0; load_w = '0; load_x = '0;
    buf_clr = 1'b0; len = '0; start = 1'b0; res_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_n_en", n_en, 0);
    check_eq("rst_n_w", n_w, 0);
    check_eq("rst_n_x", n_x, 0);
    check_eq("rst_n_rst_n", n_rst_n, 0);
    check_eq("rst_load_ready", load_ready, 0);
    check_eq("rst_res_data", res_data, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_n_rst_n", n_rst_n, 1);

    // Three unit terms: each 512*512 contributes exactly 1 to the upper half.
    for (int i = 0; i < 3; i++) load_pair(512, 512);
    load_valid = 1'b0;
    run_eval(3);
    check_eq("three_terms", expect_res(3), 3);

    // Negative-only, then cancelling pair: both ReLU to zero.
    clear_buf();
    load_pair(-512, 512);
    load_pair(512, 512);
    load_valid = 1'b0;
    run_eval(1);
    run_eval(2);

    // Rejected starts with cnt=2.
    run_eval(3);
    run_eval(0);

    // Fill to DEPTH with valid held; the 17th offer must be refused.
    clear_buf();
    for (int i = 0; i < DEPTH + 1; i++)
      load_pair($urandom_range(0, 4095), int'($urandom_range(0, 5119)) - 1024);
    load_valid = 1'b0;
    check_eq("full_count", mcnt, DEPTH);
    run_eval(DEPTH + 1);
    run_eval(DEPTH);

    // Back-pressure on the result port.
    res_ready = 1'b0;
    run_eval(5);
    held       = res_data;
    load_valid = 1'b1;
    start      = 1'b1;
    len        = 5'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_valid", res_valid, 1);
      check_eq("hold_data", res_data, exp_q.size() != 0 ? exp_q[0] : ~held);
      check_eq("hold_stable", res_data, held);
      check_eq("hold_load_ready", load_ready, 0);
      tick();
      check_eq("hold_no_err", err, 0);
      check_eq("hold_busy", busy, 1);
    end
    start      = 1'b0;
    load_valid = 1'b0;
    res_ready  = 1'b1;
    tick();
    check_eq("release_idle", busy, 0);
    check_eq("release_valid", res_valid, 0);

    // Reset in the middle of STREAM.
    start = 1'b1;
    len   = 5'd4;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check_eq("mid_stream_en", n_en, 1);
    rst        = 1'b1;
    load_valid = 1'b1;
    @(negedge clk);
    check_eq("abort_n_rst_n", n_rst_n, 0);
    check_eq("abort_load_ready", load_ready, 0);
    tick();
    rst        = 1'b0;
    load_valid = 1'b0;
    mcnt       = 0;
    check_eq("abort_idle", busy, 0);
    check_eq("abort_n_en", n_en, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid) seen++;
    end
    check_eq("abort_no_result", seen, 0);
    run_eval(1);

    check_eq("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
